// File: rtl/adder_pkg.sv
// Shared definitions for the multiword add sequencer: FSM state encodings
// and a helper for sizing the word index.
package adder_pkg;

  // State encodings shared by everything that decodes the sequencer FSM.
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_DONE = STATE_DONE
  } state_t;

  // Width of a counter that walks 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// Combinational carry-select adder for one DATA_WIDTH-bit word.
// Each BLOCK_SIZE-bit block is added twice (carry-in 0 and 1), and the real
// carry coming up the chain picks one result. The last block may be partial.
module carry_select_adder #(
  parameter int DATA_WIDTH = 4,
  parameter int BLOCK_SIZE = 1
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);

  localparam int NUM_BLOCKS = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;

  logic [DATA_WIDTH-1:0] sum0;
  logic [DATA_WIDTH-1:0] sum1;
  logic                  c0;
  logic                  c1;
  logic                  c_sel;
  int                    bit_idx;

  // Per-block dual ripple sums, then select by the incoming block carry.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    sum0    = '0;
    sum1    = '0;
    S       = '0;
    c0      = 1'b0;
    c1      = 1'b1;
    c_sel   = Cin;
    bit_idx = 0;
    for (int g = 0; g < NUM_BLOCKS; g++) begin
      // NOTE: blocking assignments here on purpose -- each bit's carry must be
      // visible to the next bit within the same evaluation.
      c0 = 1'b0;
      c1 = 1'b1;
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        bit_idx = g * BLOCK_SIZE + j;
        if (bit_idx < DATA_WIDTH) begin
          sum0[bit_idx] = A[bit_idx] ^ B[bit_idx] ^ c0;
          c0            = (A[bit_idx] & B[bit_idx]) | (c0 & (A[bit_idx] ^ B[bit_idx]));
          sum1[bit_idx] = A[bit_idx] ^ B[bit_idx] ^ c1;
          c1            = (A[bit_idx] & B[bit_idx]) | (c1 & (A[bit_idx] ^ B[bit_idx]));
          S[bit_idx]    = c_sel ? sum1[bit_idx] : sum0[bit_idx];
        end
      end
      c_sel = c_sel ? c1 : c0;
    end
    CF = c_sel;
    // Signed overflow: operands agree in sign but the result does not.
    OF = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (S[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract sequencer: accepts a W-bit A +/- B request, then
// processes one DATA_WIDTH word per cycle through a single carry-select adder,
// least significant word first, and presents S/CF/OF until consumed.
// Optional feature: define MULTIWORD_ADD_SATURATION_EN to clamp S to the
// signed max/min when the full-width operation overflows.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BLOCK_SIZE = 1,
  parameter int NUM_WORDS  = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] A,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] B,
  input  logic                            SUB,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] S,
  output logic                            CF,
  output logic                            OF
);

  localparam int                W        = DATA_WIDTH * NUM_WORDS;
  localparam int                IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
`ifdef MULTIWORD_ADD_SATURATION_EN
  localparam logic [W-1:0]      SAT_MIN  = {{(W-1){1'b0}}, 1'b1} << (W - 1);
  localparam logic [W-1:0]      SAT_MAX  = ~SAT_MIN;
`endif

  state_t                state;
  state_t                state_next;

  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic                  sub_q;
  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic [W-1:0]          s_q;
  logic                  cf_q;
  logic                  of_q;

  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] b_word;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH-1:0] add_s;
  logic                  add_cf;
  logic                  add_of;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (idx == LAST_IDX) state_next = ST_DONE;
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the current word of each operand; B is inverted for subtraction.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_word = a_q[k*DATA_WIDTH +: DATA_WIDTH];
        b_word = b_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    b_eff = b_word ^ {DATA_WIDTH{sub_q}};
  end

  carry_select_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_adder (
    .A   (a_word),
    .B   (b_eff),
    .Cin (carry),
    .S   (add_s),
    .CF  (add_cf),
    .OF  (add_of)
  );

  // Operand capture on an accepted request.
  always_ff @(posedge CLK) begin
    // NOTE: operand registers carry no reset -- they are only read in RUN,
    // which is always entered through a capture, so their reset value is moot.
    if (state == ST_IDLE && IN_VALID) begin
      a_q   <= A;
      b_q   <= B;
      sub_q <= SUB;
    end
  end

  // Word sequencing: index, inter-word carry, result words and final flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx   <= '0;
      carry <= 1'b0;
      s_q   <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            idx   <= '0;
            carry <= SUB;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == IDX_W'(k)) s_q[k*DATA_WIDTH +: DATA_WIDTH] <= add_s;
          end
          carry <= add_cf;
          if (idx == LAST_IDX) begin
            // Wrap the index instead of stepping past the last word.
            idx  <= '0;
            cf_q <= add_cf;
            of_q <= add_of;
`ifdef MULTIWORD_ADD_SATURATION_EN
            if (add_of) s_q <= a_q[W-1] ? SAT_MIN : SAT_MAX;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign S  = s_q;
  assign CF = cf_q;
  assign OF = of_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (DATA_WIDTH=4, BLOCK_SIZE=1,
// NUM_WORDS=2). Expected results come from a whole-operand arithmetic model;
// directed vectors also carry hand-computed literal results.
module tb_multiword_add_sequencer;

  localparam int DW = 4;
  localparam int BS = 1;
  localparam int NW = 2;
  localparam int W  = DW * NW;

  logic         clk = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] S;
  logic         CF;
  logic         OF;

  int           tests = 0;
  int           fails = 0;

  logic         exp_pending = 1'b0;
  logic [W-1:0] exp_s;
  logic         exp_cf;
  logic         exp_of;

  multiword_add_sequencer #(
    .DATA_WIDTH (DW),
    .BLOCK_SIZE (BS),
    .NUM_WORDS  (NW)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .CF        (CF),
    .OF        (OF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-operand model using signed/unsigned integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic cf, output logic of);
    longint ua, ub, sa, sb, r, u, full;
    full = longint'(1) << W;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[W-1] ? ua - full : ua;
    sb   = b[W-1] ? ub - full : ub;
    if (sub) begin
      u  = ua - ub;
      cf = (ua >= ub);
      r  = sa - sb;
    end else begin
      u  = ua + ub;
      cf = (u >= full);
      r  = sa + sb;
    end
    of = (r > (full / 2) - 1) || (r < -(full / 2));
    s  = W'(u);
`ifdef MULTIWORD_ADD_SATURATION_EN
    if (of) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  endtask

  // Compare DUT outputs against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (RST === 1'b0) begin
      check("ready_valid_exclusive", 32'(IN_READY & OUT_VALID), 32'd0);
      if (OUT_VALID === 1'b1 && !exp_pending)
        check("out_valid_unexpected", 32'(OUT_VALID), 32'(exp_pending));
      if (OUT_VALID === 1'b1 && exp_pending) begin
        check("model_s",  32'(S),  32'(exp_s));
        check("model_cf", 32'(CF), 32'(exp_cf));
        check("model_of", 32'(OF), 32'(exp_of));
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (IN_READY !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(IN_READY), 32'd1);
  endtask

  // One full transaction; holds OUT_READY low for 'hold' cycles in DONE
  // while scrambling the ignored inputs.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, output logic [W-1:0] s, output logic cf,
                        output logic of);
    int lat;
    model(a, b, sub, exp_s, exp_cf, exp_of);
    exp_pending = 1'b1;
    wait_ready();
    A        = a;
    B        = b;
    SUB      = sub;
    IN_VALID = 1'b1;
    @(negedge clk);
    IN_VALID = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    SUB      = 1'($urandom);
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(NW));
    s  = S;
    cf = CF;
    of = OF;
    for (int i = 0; i < hold; i++) begin
      OUT_READY = 1'b0;
      IN_VALID  = 1'($urandom);
      A         = W'($urandom);
      B         = W'($urandom);
      @(negedge clk);
      check("hold_s",        32'(S),         32'(s));
      check("hold_cf",       32'(CF),        32'(cf));
      check("hold_of",       32'(OF),        32'(of));
      check("hold_in_ready", 32'(IN_READY),  32'd0);
      check("hold_valid",    32'(OUT_VALID), 32'd1);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge clk);
    check("release_in_ready",  32'(IN_READY),  32'd1);
    check("release_out_valid", 32'(OUT_VALID), 32'd0);
    OUT_READY   = 1'b0;
    exp_pending = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    logic         cf;
    logic         of;

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    A         = '0;
    B         = '0;
    SUB       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(IN_READY),  32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_s",         32'(S),         32'd0);
    check("rst_cf",        32'(CF),        32'd0);
    check("rst_of",        32'(OF),        32'd0);
    RST = 1'b0;
    @(negedge clk);

    // Basic add, released immediately.
    run_op(8'h15, 8'h4C, 1'b0, 0, s, cf, of);
    check("lit_15p4c_s", 32'(s), 32'h61);
    check("lit_15p4c_cf", 32'(cf), 32'd0);
    check("lit_15p4c_of", 32'(of), 32'd0);

    // Signed overflow on add.
    run_op(8'h7F, 8'h01, 1'b0, 0, s, cf, of);
`ifdef MULTIWORD_ADD_SATURATION_EN
    check("lit_7fp01_s", 32'(s), 32'h7F);
`else
    check("lit_7fp01_s", 32'(s), 32'h80);
`endif
    check("lit_7fp01_cf", 32'(cf), 32'd0);
    check("lit_7fp01_of", 32'(of), 32'd1);

    // Unsigned carry out, no signed overflow.
    run_op(8'hFF, 8'h01, 1'b0, 0, s, cf, of);
    check("lit_ffp01_s", 32'(s), 32'h00);
    check("lit_ffp01_cf", 32'(cf), 32'd1);
    check("lit_ffp01_of", 32'(of), 32'd0);

    // Subtract with borrow.
    run_op(8'h10, 8'h20, 1'b1, 0, s, cf, of);
    check("lit_10m20_s", 32'(s), 32'hF0);
    check("lit_10m20_cf", 32'(cf), 32'd0);
    check("lit_10m20_of", 32'(of), 32'd0);

    // Subtract with signed overflow, held in DONE for five cycles.
    run_op(8'h80, 8'h01, 1'b1, 5, s, cf, of);
`ifdef MULTIWORD_ADD_SATURATION_EN
    check("lit_80m01_s", 32'(s), 32'h80);
`else
    check("lit_80m01_s", 32'(s), 32'h7F);
`endif
    check("lit_80m01_cf", 32'(cf), 32'd1);
    check("lit_80m01_of", 32'(of), 32'd1);

    // Further patterns checked by the model.
    run_op(8'h00, 8'h00, 1'b1, 0, s, cf, of);
    check("lit_00m00_cf", 32'(cf), 32'd1);
    run_op(8'h80, 8'h80, 1'b0, 2, s, cf, of);
    check("lit_80p80_cf", 32'(cf), 32'd1);
    check("lit_80p80_of", 32'(of), 32'd1);
    run_op(8'hFF, 8'hFF, 1'b0, 0, s, cf, of);
    check("lit_ffpff_s", 32'(s), 32'hFE);
    run_op(8'h3A, 8'hC5, 1'b1, 1, s, cf, of);
    check("lit_3amc5_s", 32'(s), 32'h75);

    // Reset in the middle of RUN (word index 1) discards the operation.
    wait_ready();
    A        = 8'h15;
    B        = 8'h4C;
    SUB      = 1'b0;
    IN_VALID = 1'b1;
    @(negedge clk);
    IN_VALID = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("midrst_in_ready",  32'(IN_READY),  32'd1);
    check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
    check("midrst_s",         32'(S),         32'd0);
    check("midrst_cf",        32'(CF),        32'd0);
    check("midrst_of",        32'(OF),        32'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(OUT_VALID), 32'd0);
    end
    run_op(8'h15, 8'h4C, 1'b0, 0, s, cf, of);
    check("post_rst_s", 32'(s), 32'h61);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
